pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage MIPS core. Each cycle it decides which stages stall and whether the pipeline is flushed to a new PC. It generates stalls for load-use hazards detected against the decode stage and for multi-cycle MULT occupancy of the execute stage. It also tracks the branch delay-slot flag fed back into decode, and (optionally) redirects the fetch PC on exceptions and ERET.

## Interface
Parameters:
- MUL_CYCLES, 4: total EX-stage cycles a MULT occupies; legal range 1..16.
- EXC_VECTOR, 32'h0000_0040: exception handler PC.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising edge).
- id_reg1_read_i  in  1  decode reads source 1.
- id_reg1_addr_i  in  5  decode source 1 register number.
- id_reg2_read_i  in  1  decode reads source 2.
- id_reg2_addr_i  in  5  decode source 2 register number.
- id_next_inst_in_delayslot_i  in  1  decode holds a taken branch/jump.
- ex_load_i  in  1  EX-stage instruction is a load (LW/LB/LBU/LHU).
- ex_wd_i  in  5  EX-stage destination register.
- ex_mult_i  in  1  EX-stage instruction is MULT.
- mem_exc_i  in  1  MEM-stage instruction raised an exception.
- mem_eret_i  in  1  MEM-stage instruction is ERET.
- cp0_epc_i  in  32  current EPC.
- stall_o  out  6  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush_o  out  1  clear all pipeline registers this cycle.
- new_pc_o  out  32  fetch target, valid while flush_o=1.
- is_in_delayslot_o  out  1  registered delay-slot flag for the instruction now in decode.
- mult_done_o  out  1  final EX cycle of a MULT.

## Operation
- Load-use hazard (lu):
  - ex_load_i=1, ex_wd_i!=0, and either (id_reg1_read_i and id_reg1_addr_i==ex_wd_i) or (id_reg2_read_i and id_reg2_addr_i==ex_wd_i).
  - Stall is 6'b000111. The EX stage receives a bubble.
- MULT sequencer, 4-bit counter cnt:
  - Start: cnt==0 and ex_mult_i=1. cnt <= MUL_CYCLES-1.
  - Stall 6'b001111 in the start cycle when MUL_CYCLES>1, and in every cycle with cnt>1.
  - cnt>1: cnt decrements.
  - cnt==1: no MULT stall, mult_done_o=1, cnt <= 0.
  - MUL_CYCLES==1: mult_done_o=1 in the start cycle and no stall.
  - ex_mult_i is ignored while cnt!=0.
- Stall priority:
  - flush: stall_o=0.
  - Otherwise MULT stall (001111) has priority over lu (000111).
  - Otherwise stall_o=0.
- Delay-slot register ds:
  - flush: ds <= 0.
  - Else if stall_o[2]: ds holds.
  - Else: ds <= id_next_inst_in_delayslot_i.
- Exception redirect (EXC feature):
  - mem_exc_i=1: flush_o=1, new_pc_o=EXC_VECTOR.
  - Else mem_eret_i=1: flush_o=1, new_pc_o=cp0_epc_i.
  - mem_exc_i has priority over mem_eret_i.
  - flush_o=1 also forces cnt <= 0 and mult_done_o=0.
- When flush_o=0, new_pc_o=0.

## Timing
- stall_o, flush_o, new_pc_o and mult_done_o are combinational from the inputs and cnt. They take effect at the same edge.
- is_in_delayslot_o is registered, so it reflects a branch one cycle after the branch leaves decode.
- Reset (rst==0 at an edge): cnt=0, ds=0. While rst==0, all outputs are forced to 0 regardless of inputs.
- Reset asserted mid-MULT abandons the count. No mult_done_o is produced.
- A MULT held in EX for MUL_CYCLES cycles sees stall_o[3]=1 for MUL_CYCLES-1 of them.
- Simultaneous lu and MULT stall: stall_o=001111; lu is re-evaluated once EX advances.
- Simultaneous flush and any stall source: flush wins, stall_o=0.

## Configuration
- PIPE_CTRL_EXC_EN defined: exception/ERET flush logic is present as described.
- PIPE_CTRL_EXC_EN undefined:
  - flush_o is tied to 0 and new_pc_o to 0.
  - mem_exc_i, mem_eret_i and cp0_epc_i are unused.
  - ds and cnt never clear except by reset.

## Test plan
- LW $2 in EX (ex_load_i=1, ex_wd_i=2); ID reads reg1=2 -> stall_o=6'b000111 for exactly one cycle. Same case with ex_wd_i=0 -> stall_o=0.
- MUL_CYCLES=4, ex_mult_i held until EX advances:
  - stall_o=6'b001111 for 3 cycles.
  - mult_done_o=1 in the 4th cycle.
  - stall_o=0 afterwards.
  - With MUL_CYCLES=1: no stall and mult_done_o=1 in one cycle.
- BEQ taken in decode (id_next_inst_in_delayslot_i=1, no stall) -> is_in_delayslot_o=1 next cycle, 0 the cycle after. If a lu stall occurs meanwhile, the flag holds.
- With PIPE_CTRL_EXC_EN:
  - mem_exc_i=1 during MULT cnt=2 -> flush_o=1, new_pc_o=32'h40, stall_o=0; next cycle cnt=0, is_in_delayslot_o=0.
  - mem_eret_i=1 with cp0_epc_i=32'h8000_1234 -> new_pc_o=32'h8000_1234.
  - Both mem_exc_i and mem_eret_i high -> new_pc_o=EXC_VECTOR.
- rst=0 asserted during a MULT (cnt=3) -> all outputs 0. After rst=1, a new ex_mult_i restarts a full MUL_CYCLES sequence.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: load-use and MULT stalls, delay-slot flag, exception redirect.
// Stall/flush outputs are combinational; optional exception/ERET redirect built when PIPE_CTRL_EXC_EN is defined.
module pipe_ctrl #(
  parameter int          MUL_CYCLES = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  input  logic        id_next_inst_in_delayslot_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_mult_i,
  input  logic        mem_exc_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        is_in_delayslot_o,
  output logic        mult_done_o
);

  logic [3:0]  cnt_q, cnt_d;
  logic        ds_q, ds_d;
  logic        flush;
  logic [31:0] new_pc;
  logic        lu;
  logic        mult_start;
  logic        mult_stall;
  logic        mult_done;
  logic [5:0]  stall;

`ifdef PIPE_CTRL_EXC_EN
  always_comb begin
    flush  = mem_exc_i | mem_eret_i;
    new_pc = '0;
    if (mem_exc_i)       new_pc = EXC_VECTOR;
    else if (mem_eret_i) new_pc = cp0_epc_i;
  end
`else
  assign flush  = 1'b0;
  assign new_pc = '0;
  logic unused_exc;
  assign unused_exc = ^{mem_exc_i, mem_eret_i, cp0_epc_i};
`endif

  assign lu = ex_load_i && (ex_wd_i != 5'd0) &&
              ((id_reg1_read_i && (id_reg1_addr_i == ex_wd_i)) ||
               (id_reg2_read_i && (id_reg2_addr_i == ex_wd_i)));

  // A new MULT is only accepted when the sequencer is idle.
  assign mult_start = (cnt_q == 4'd0) && ex_mult_i;
  assign mult_stall = (mult_start && (MUL_CYCLES > 1)) || (cnt_q > 4'd1);
  assign mult_done  = !flush && ((mult_start && (MUL_CYCLES == 1)) || (cnt_q == 4'd1));

  always_comb begin
    stall = 6'b000000;
    if (flush)           stall = 6'b000000;
    else if (mult_stall) stall = 6'b001111;
    else if (lu)         stall = 6'b000111;
  end

  always_comb begin
    cnt_d = 4'd0;
    if (flush)              cnt_d = 4'd0;
    else if (mult_start)    cnt_d = 4'(MUL_CYCLES - 1);
    else if (cnt_q > 4'd1)  cnt_d = cnt_q - 4'd1;

    ds_d = id_next_inst_in_delayslot_i;
    if (flush)         ds_d = 1'b0;
    else if (stall[2]) ds_d = ds_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'd0;
      ds_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ds_q  <= ds_d;
    end
  end

  // Reset gates every output, including the registered flag before the first reset edge.
  assign stall_o           = rst ? stall : 6'b000000;
  assign flush_o           = rst & flush;
  assign new_pc_o          = rst ? new_pc : 32'd0;
  assign is_in_delayslot_o = rst & ds_q;
  assign mult_done_o       = rst & mult_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-derived expectations queued per cycle, compared mid-cycle.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_reg1_read_i, id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
  logic        id_next_inst_in_delayslot_i;
  logic        ex_load_i, ex_mult_i;
  logic [4:0]  ex_wd_i;
  logic        mem_exc_i, mem_eret_i;
  logic [31:0] cp0_epc_i;

  logic [5:0]  stall_o, d1_stall;
  logic        flush_o, d1_flush;
  logic [31:0] new_pc_o, d1_new_pc;
  logic        ds_o, d1_ds;
  logic        done_o, d1_done;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        ds;
    logic        dn;
    logic        c1;
    logic [5:0]  st1;
    logic        dn1;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_next_inst_in_delayslot_i(id_next_inst_in_delayslot_i),
    .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i), .ex_mult_i(ex_mult_i),
    .mem_exc_i(mem_exc_i), .mem_eret_i(mem_eret_i), .cp0_epc_i(cp0_epc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .is_in_delayslot_o(ds_o), .mult_done_o(done_o)
  );

  pipe_ctrl #(.MUL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_next_inst_in_delayslot_i(id_next_inst_in_delayslot_i),
    .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i), .ex_mult_i(ex_mult_i),
    .mem_exc_i(mem_exc_i), .mem_eret_i(mem_eret_i), .cp0_epc_i(cp0_epc_i),
    .stall_o(d1_stall), .flush_o(d1_flush), .new_pc_o(d1_new_pc),
    .is_in_delayslot_o(d1_ds), .mult_done_o(d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                      input logic ds, input logic dn);
    exp_t e;
    e = '{st: st, fl: fl, pc: pc, ds: ds, dn: dn, c1: 1'b0, st1: 6'd0, dn1: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push1(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                       input logic ds, input logic dn, input logic [5:0] st1, input logic dn1);
    exp_t e;
    e = '{st: st, fl: fl, pc: pc, ds: ds, dn: dn, c1: 1'b1, st1: st1, dn1: dn1};
    sb.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b1;
    id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
    id_next_inst_in_delayslot_i = 1'b0;
    ex_load_i = 1'b0; ex_wd_i = 5'd0; ex_mult_i = 1'b0;
    mem_exc_i = 1'b0; mem_eret_i = 1'b0; cp0_epc_i = 32'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", {26'd0, stall_o}, {26'd0, e.st});
      chk("flush", {31'd0, flush_o}, {31'd0, e.fl});
      chk("new_pc", new_pc_o, e.pc);
      chk("delayslot", {31'd0, ds_o}, {31'd0, e.ds});
      chk("mult_done", {31'd0, done_o}, {31'd0, e.dn});
      if (e.c1) begin
        chk("m1_stall", {26'd0, d1_stall}, {26'd0, e.st1});
        chk("m1_done", {31'd0, d1_done}, {31'd0, e.dn1});
        chk("m1_flush", {31'd0, d1_flush}, {31'd0, e.fl});
        chk("m1_new_pc", d1_new_pc, e.pc);
        chk("m1_delayslot", {31'd0, d1_ds}, {31'd0, e.ds});
      end
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    // reset forces outputs low even with hazards present
    cyc(); rst = 1'b0; ex_mult_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd2;
           id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd2;
           push1(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000000, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    // load-use on reg1, then EX advances
    cyc(); ex_load_i = 1'b1; ex_wd_i = 5'd2; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd2;
           push(6'b000111, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_load_i = 1'b1; ex_wd_i = 5'd0; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd0;
           push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_load_i = 1'b1; ex_wd_i = 5'd7; id_reg1_addr_i = 5'd7;
           id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd7;
           push(6'b000111, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_load_i = 1'b1; ex_wd_i = 5'd7; id_reg1_addr_i = 5'd7; id_reg2_addr_i = 5'd7;
           push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    // MULT held in EX for four cycles; single-cycle instance completes at once
    cyc(); ex_mult_i = 1'b1; push1(6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000000, 1'b1);
    cyc(); ex_mult_i = 1'b1; push(6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_mult_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd3;
           id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd3;
           push(6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_mult_i = 1'b1; push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b1);
    cyc(); push1(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000000, 1'b0);
    // delay-slot flag: plain pulse, then held across a load-use stall
    cyc(); id_next_inst_in_delayslot_i = 1'b1; push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(); id_next_inst_in_delayslot_i = 1'b1; push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); ex_load_i = 1'b1; ex_wd_i = 5'd4; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd4;
           push(6'b000111, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(); id_next_inst_in_delayslot_i = 1'b1; push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    // exception arrives while the MULT counter is at 2
    cyc(); ex_mult_i = 1'b1; id_next_inst_in_delayslot_i = 1'b1;
           push(6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(); ex_mult_i = 1'b1; id_next_inst_in_delayslot_i = 1'b1;
           push(6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(); ex_mult_i = 1'b1; mem_exc_i = 1'b1; id_next_inst_in_delayslot_i = 1'b1;
           push(EXC ? 6'b000000 : 6'b001111, EXC, EXC ? 32'h0000_0040 : 32'd0, 1'b1, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, EXC ? 1'b0 : 1'b1, EXC ? 1'b0 : 1'b1);
    cyc(); mem_eret_i = 1'b1; cp0_epc_i = 32'h8000_1234;
           push(6'b000000, EXC, EXC ? 32'h8000_1234 : 32'd0, 1'b0, 1'b0);
    cyc(); mem_exc_i = 1'b1; mem_eret_i = 1'b1; cp0_epc_i = 32'h8000_1234;
           ex_load_i = 1'b1; ex_wd_i = 5'd5; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd5;
           push(EXC ? 6'b000000 : 6'b000111, EXC, EXC ? 32'h0000_0040 : 32'd0, 1'b0, 1'b0);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    // reset during a MULT abandons it; a fresh MULT runs the full sequence
    cyc(); ex_mult_i = 1'b1; push(6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(); rst = 1'b0; ex_mult_i = 1'b1; id_next_inst_in_delayslot_i = 1'b1;
           push1(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); ex_mult_i = 1'b1; push(6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    cyc(); ex_mult_i = 1'b1; push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b1);
    cyc(); push(6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
